// File: rtl/coeff_token_flc_writer.sv
// CAVLC coeff_token writer for nC >= 8: serialises the 6-bit fixed-length codeword
// MSB-first, then the trailing-one sign flags, on a valid/ready bit stream.
module coeff_token_flc_writer #(
    parameter bit          ENABLE_SIGNS    = 1'b1,
    parameter int unsigned MAX_TOTAL_COEFF = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       InValid,
    output logic       InReady,
    input  logic [4:0] TotalCoeff,
    input  logic [1:0] TrailingOnes,
    input  logic [2:0] T1Signs,
    output logic       BitOut,
    output logic       BitValid,
    input  logic       BitReady,
    output logic       BitLast,
    output logic       Error
);

    typedef enum logic [1:0] {IDLE, CODE, SIGN, DONE_STEP} state_t;

    localparam logic [5:0] MAX_TC_C = 6'(MAX_TOTAL_COEFF);

    // Fixed-length table: TotalCoeff=0 has its own escape code; 16 wraps to 4'b1111.
    function automatic logic [5:0] flc_codeword(input logic [4:0] tc, input logic [1:0] t1);
        logic [4:0] tc_m1;
        tc_m1 = tc - 5'd1;
        if (tc == 5'd0) begin
            flc_codeword = 6'b000011;
        end else begin
            flc_codeword = {tc_m1[3:0], t1};
        end
    endfunction

    state_t     state_r;
    logic       in_ready_r;
    logic       bit_out_r;
    logic       bit_valid_r;
    logic       bit_last_r;
    logic       error_r;
    logic [8:0] shift_r;
    logic [3:0] bit_cnt_r;
    logic [3:0] len_r;

    logic       illegal_s;
    logic       accept_s;
    logic       fire_s;
    logic       last_s;
    logic [2:0] sign_seq_s;
    logic [8:0] seq_s;
    logic [3:0] len_s;
    logic [3:0] next_cnt_s;

    // Token legality, emission sequence and handshake decode.
    always_comb begin
        illegal_s  = ({1'b0, TotalCoeff} > MAX_TC_C) ||
                     ({3'b000, TrailingOnes} > TotalCoeff);
        accept_s   = InValid && in_ready_r;
        fire_s     = bit_valid_r && BitReady;
        last_s     = (bit_cnt_r == (len_r - 4'd1));
        next_cnt_s = bit_cnt_r + 4'd1;
        // Sign bit0 goes out first; unused positions fall past the latched length.
        sign_seq_s = ENABLE_SIGNS ? {T1Signs[0], T1Signs[1], T1Signs[2]} : 3'b000;
        seq_s      = {flc_codeword(TotalCoeff, TrailingOnes), sign_seq_s};
        len_s      = 4'd6 + (ENABLE_SIGNS ? {2'b00, TrailingOnes} : 4'd0);
    end

    // Token FSM with registered stream outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            bit_last_r  <= 1'b0;
            error_r     <= 1'b0;
            shift_r     <= 9'd0;
            bit_cnt_r   <= 4'd0;
            len_r       <= 4'd0;
        end else begin
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        if (illegal_s) begin
                            error_r <= 1'b1;
                        end else begin
                            state_r     <= CODE;
                            in_ready_r  <= 1'b0;
                            bit_out_r   <= seq_s[8];
                            shift_r     <= {seq_s[7:0], 1'b0};
                            bit_valid_r <= 1'b1;
                            bit_last_r  <= 1'b0;
                            bit_cnt_r   <= 4'd0;
                            len_r       <= len_s;
                        end
                    end
                end
                CODE, SIGN: begin
                    if (fire_s) begin
                        if (last_s) begin
                            state_r     <= IDLE;
                            in_ready_r  <= 1'b1;
                            bit_out_r   <= 1'b0;
                            bit_valid_r <= 1'b0;
                            bit_last_r  <= 1'b0;
                            bit_cnt_r   <= 4'd0;
                        end else begin
                            state_r    <= (next_cnt_s >= 4'd6) ? SIGN : CODE;
                            bit_out_r  <= shift_r[8];
                            shift_r    <= {shift_r[7:0], 1'b0};
                            bit_cnt_r  <= next_cnt_s;
                            bit_last_r <= (next_cnt_s == (len_r - 4'd1));
                        end
                    end
                end
                DONE_STEP: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    bit_valid_r <= 1'b0;
                    bit_last_r  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    bit_valid_r <= 1'b0;
                    bit_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign InReady  = in_ready_r;
    assign BitOut   = bit_out_r;
    assign BitValid = bit_valid_r;
    assign BitLast  = bit_last_r;
    assign Error    = error_r;

endmodule

// File: doc/coeff_token_flc_writer.md
Name: coeff_token_flc_writer

Overview:
- Encoder-side counterpart of the CAVLC coeff_token decode lookups.
- Accepts one (TotalCoeff, TrailingOnes, trailing-one signs) token per handshake for blocks with nC >= 8, which use the 6-bit fixed-length coeff_token table.
- Serialises the 6-bit codeword MSB-first, followed by the trailing_ones_sign_flag bits, one bit per cycle on a valid/ready bit stream.
- Sits between the residual-block analyser and the bitstream packer.

Parameters:
- ENABLE_SIGNS, 1: when 1, append TrailingOnes sign bits after the codeword; when 0, emit only the 6-bit codeword and ignore T1Signs.
- MAX_TOTAL_COEFF, 16: largest legal TotalCoeff. Use 15 for AC blocks.

Ports:
- Clk  input  1  clock; all logic rising-edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  token present.
- InReady  output  1  block can accept a token.
- TotalCoeff  input  5  number of nonzero coefficients, 0..MAX_TOTAL_COEFF.
- TrailingOnes  input  2  number of trailing +/-1 coefficients, 0..3.
- T1Signs  input  3  sign per trailing one, 1 = negative; bit0 is emitted first.
- BitOut  output  1  serial bit.
- BitValid  output  1  BitOut valid.
- BitReady  input  1  downstream accepts BitOut.
- BitLast  output  1  qualifies the final bit of the current token.
- Error  output  1  one-cycle pulse: illegal token dropped.

Behaviour:
- Reset values: InReady=0 during reset, 1 in the first cycle after; BitOut=0; BitValid=0; BitLast=0; Error=0; FSM=IDLE; bit counter=0.
- A token is accepted in a cycle where InValid && InReady. InReady=1 only in IDLE.
- Legality check at accept. A token is illegal if any of these hold:
  - TotalCoeff > MAX_TOTAL_COEFF
  - TrailingOnes > 3
  - TrailingOnes > TotalCoeff
- Illegal token: Error=1 for exactly the next cycle; FSM stays IDLE; no bits are emitted; the token is consumed.
- Codeword for a legal token (6 bits):
  - TotalCoeff=0: 6'b000011.
  - Otherwise: {TotalCoeff-1 [3:0], TrailingOnes[1:0]}.
  - Compute width-exact in 4 bits; TotalCoeff=16 gives 4'b1111.
- Latched at accept: codeword, sign bits, and length L = 6 + (ENABLE_SIGNS ? TrailingOnes : 0).
- FSM states:
  - IDLE: on a legal accept, go to CODE.
  - CODE: present codeword bit 5 down to bit 0.
  - SIGN: present T1Signs[0], then [1], then [2], limited to TrailingOnes bits.
  - DONE_STEP: return to IDLE.
- Transitions:
  - CODE -> SIGN after the bit-0 handshake, if sign bits remain.
  - Otherwise CODE -> IDLE after that handshake.
  - SIGN -> IDLE after the last sign-bit handshake.
- Latency: token accepted at cycle N; first bit has BitValid=1 at cycle N+1.
- Output register rules:
  - A bit advances only on BitValid && BitReady.
  - While BitReady=0, BitOut, BitValid and BitLast hold stable.
  - BitValid never drops mid-token.
- BitLast=1 exactly while bit L-1 is presented.
- After the last handshake: BitValid=0 and InReady=1 in the next cycle. This gives one bubble cycle between tokens, so with BitReady=1 held, a token occupies L+1 cycles.
- Input fields are sampled only at accept; changes while busy are ignored.
- Reset asserted mid-token: the token is aborted, the bit stream truncates, and all outputs go to reset values on the next edge. No partial resume.

Test Plan:
- TotalCoeff=0, TrailingOnes=0, BitReady=1 -> bits 0,0,0,0,1,1. BitLast on the 6th bit. InReady returns 1 one cycle after.
- TotalCoeff=5, TrailingOnes=0 -> bits 0,1,0,0,0,0. First BitValid one cycle after accept.
- TotalCoeff=9, TrailingOnes=3, T1Signs=3'b101 -> bits 1,0,0,0,1,1 then 1,0,1. 9 bits total; BitLast only on the 9th.
- TotalCoeff=16, TrailingOnes=3, T1Signs=3'b000, BitReady toggling 1,0,0,1,... -> bits 1,1,1,1,1,1,0,0,0. BitOut, BitValid and BitLast stable while BitReady=0.
- Illegal tokens TotalCoeff=2, TrailingOnes=3 and TotalCoeff=17, TrailingOnes=0 -> Error pulses 1 cycle each; no BitValid; next legal token encodes normally.
- Reset asserted after the 3rd bit of a TotalCoeff=7, TrailingOnes=2 token -> BitValid=0, InReady=1 after reset release. A new TotalCoeff=1, TrailingOnes=1, T1Signs=1 token yields 0,0,0,0,0,1,1.
